// File: rtl/receive_if.sv
// receive_if: channel-memory port and result bundle for the receive engine.
// Widths follow addrBits/dataBits; error is present only with RECEIVE_ERROR_EN.
// master = sequencer/memory side, slave = receive engine.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

interface receive_if #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
);
    logic                start;
    logic                busy;
    logic                finished;
    logic [addrBits-1:0] address;
    logic                readWriteMode;
    logic [dataBits-1:0] dataOut;
    logic [dataBits-1:0] dataIn;
    logic [addrBits-1:0] channel;
    logic [addrBits-1:0] rxPid;
    logic                shouldScheduleSender;
    logic                shouldDescheduleReceiver;
    logic [addrBits-1:0] scheduleTxPid;
    logic                messageValid;
    logic [dataBits-1:0] receivedMessage;
`ifdef RECEIVE_ERROR_EN
    logic                error;
`endif

    modport master (
        output start, dataOut, channel, rxPid,
`ifdef RECEIVE_ERROR_EN
        input  error,
`endif
        input  busy, finished, address, readWriteMode, dataIn,
               shouldScheduleSender, shouldDescheduleReceiver,
               scheduleTxPid, messageValid, receivedMessage
    );

    modport slave (
        input  start, dataOut, channel, rxPid,
`ifdef RECEIVE_ERROR_EN
        output error,
`endif
        output busy, finished, address, readWriteMode, dataIn,
               shouldScheduleSender, shouldDescheduleReceiver,
               scheduleTxPid, messageValid, receivedMessage
    );
endinterface

// File: rtl/receive.sv
// receive: channel rendezvous receiver; parks the receiver or takes a waiting sender's message (RECEIVE_ERROR_EN adds self-wait error).
// Latency: start in T, single channel write in T+2, finished and results in T+3, idle again in T+4.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module receive #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input  logic     clk,
    input  logic     reset,
    receive_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_PID = 2'd1,
        DECIDE   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [addrBits-1:0] channelReg;
    logic [addrBits-1:0] rxPidReg;
    logic [addrBits-1:0] pendingPid;
    logic                selfWait;

    logic                scheduleReg;
    logic                descheduleReg;
    logic [addrBits-1:0] txPidReg;
    logic                validReg;
    logic [dataBits-1:0] messageReg;

    // A receiver finding its own PID parked on the channel is only an error when checking is built in.
`ifdef RECEIVE_ERROR_EN
    logic errorReg;
    assign selfWait  = (pendingPid == rxPidReg);
    assign bus.error = errorReg;
`else
    assign selfWait = 1'b0;
`endif

    assign bus.busy                     = (state != IDLE);
    assign bus.finished                 = (state == DONE);
    assign bus.shouldScheduleSender     = scheduleReg;
    assign bus.shouldDescheduleReceiver = descheduleReg;
    assign bus.scheduleTxPid            = txPidReg;
    assign bus.messageValid             = validReg;
    assign bus.receivedMessage          = messageReg;

    // State register; reset drops straight to IDLE so an in-flight write is abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next state and memory port decode; the only write is the channel word in DECIDE.
    always_comb begin
        nextState         = state;
        bus.address       = bus.channel;
        bus.readWriteMode = `RAM_READ;
        bus.dataIn        = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) nextState = READ_PID;
            end
            READ_PID: begin
                bus.address = channelReg + addrBits'(1);
                nextState   = DECIDE;
            end
            DECIDE: begin
                bus.address = channelReg;
                if (!selfWait) begin
                    bus.readWriteMode = `RAM_WRITE;
                    // Empty channel parks our PID; a waiting sender's slot is cleared.
                    bus.dataIn = (pendingPid == '0) ? dataBits'(rxPidReg) : '0;
                end
                nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Operand latches and result registers; results clear on an accepted start and settle at the DECIDE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            channelReg    <= '0;
            rxPidReg      <= '0;
            pendingPid    <= '0;
            scheduleReg   <= 1'b0;
            descheduleReg <= 1'b0;
            txPidReg      <= '0;
            validReg      <= 1'b0;
            messageReg    <= '0;
`ifdef RECEIVE_ERROR_EN
            errorReg      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        channelReg    <= bus.channel;
                        rxPidReg      <= bus.rxPid;
                        scheduleReg   <= 1'b0;
                        descheduleReg <= 1'b0;
                        txPidReg      <= '0;
                        validReg      <= 1'b0;
                        messageReg    <= '0;
`ifdef RECEIVE_ERROR_EN
                        errorReg      <= 1'b0;
`endif
                    end
                end
                READ_PID: begin
                    // Only the low addrBits of the waiting-process word form a PID.
                    pendingPid <= bus.dataOut[addrBits-1:0];
                end
                DECIDE: begin
                    if (selfWait) begin
`ifdef RECEIVE_ERROR_EN
                        errorReg <= 1'b1;
`endif
                    end else if (pendingPid == '0) begin
                        descheduleReg <= 1'b1;
                    end else begin
                        scheduleReg <= 1'b1;
                        txPidReg    <= pendingPid;
                        messageReg  <= bus.dataOut;
                        validReg    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_receive.sv
// tb_receive: directed and randomized checks of the receive engine against a rule-level model.
// Memory model: registered read data, write applied at the clock edge.
// Inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_receive;
    localparam int AB = `ADDRESS_BITS;
    localparam int DB = `DATA_BITS;
    localparam int MEMWORDS = 1 << AB;
`ifdef RECEIVE_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    receive_if #(.addrBits(AB), .dataBits(DB)) bus();
    receive #(.addrBits(AB), .dataBits(DB)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DB-1:0] mem [MEMWORDS];
    logic          pokeEn = 1'b0;
    logic [AB-1:0] pokeAddr = '0;
    logic [DB-1:0] pokeData = '0;
    int            writeCount = 0;
    int            tests = 0;
    int            failures = 0;

    // Channel memory: bench preload has priority; DUT writes counted.
    always @(posedge clk) begin
        if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end else if (bus.readWriteMode == `RAM_WRITE) begin
            mem[bus.address] <= bus.dataIn;
            writeCount <= writeCount + 1;
        end
        bus.dataOut <= mem[bus.address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the write lands at the next rising edge.
    task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
        pokeEn = 1'b1; pokeAddr = a; pokeData = d;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    // One receive operation from a falling edge with the engine idle. Optionally keeps start
    // high while busy, and optionally schedules a preload to land just after completion.
    task automatic runOp(input logic [AB-1:0] ch, input logic [AB-1:0] rx, input bit holdStart,
                         input bit chainPoke, input logic [AB-1:0] pa, input logic [DB-1:0] pd);
        logic [AB-1:0] msgAddr;
        logic [DB-1:0] w0, w1, expWData, expMem0;
        logic [AB-1:0] pid, expTx;
        logic [DB-1:0] expMsg;
        bit expErr, expWrite, expDesched, expSched;
        int wc0;
        pokeEn = 1'b0;
        msgAddr = ch + AB'(1);
        w0 = mem[ch];
        w1 = mem[msgAddr];
        pid = w0[AB-1:0];
        // Rendezvous rules
        expErr     = ERR_EN && (pid == rx);
        expWrite   = !expErr;
        expDesched = !expErr && (pid == 0);
        expSched   = !expErr && (pid != 0);
        expWData   = (pid == 0) ? DB'(rx) : '0;
        expMem0    = expWrite ? expWData : w0;
        expTx      = expSched ? pid : '0;
        expMsg     = expSched ? w1 : '0;
        wc0 = writeCount;

        bus.start = 1'b1; bus.channel = ch; bus.rxPid = rx;
        @(negedge clk); // T+1
        chk("busy_t1", bus.busy, 1);
        chk("addr_t1", bus.address, msgAddr);
        chk("rw_t1", bus.readWriteMode, `RAM_READ);
        chk("cleared_sched", bus.shouldScheduleSender, 0);
        chk("cleared_desched", bus.shouldDescheduleReceiver, 0);
        chk("cleared_valid", bus.messageValid, 0);
        chk("cleared_txpid", bus.scheduleTxPid, 0);
        bus.start = holdStart;
        bus.channel = AB'($urandom);
        bus.rxPid = AB'($urandom);
        @(negedge clk); // T+2
        chk("finished_t2", bus.finished, 0);
        chk("addr_t2", bus.address, ch);
        chk("rw_t2", bus.readWriteMode, expWrite ? `RAM_WRITE : `RAM_READ);
        if (expWrite) chk("wdata_t2", bus.dataIn, expWData);
        @(negedge clk); // T+3
        chk("finished_t3", bus.finished, 1);
        chk("busy_t3", bus.busy, 1);
        chk("rw_t3", bus.readWriteMode, `RAM_READ);
        chk("desched", bus.shouldDescheduleReceiver, expDesched);
        chk("sched", bus.shouldScheduleSender, expSched);
        chk("txpid", bus.scheduleTxPid, expTx);
        chk("msgvalid", bus.messageValid, expSched);
        chk("message", bus.receivedMessage, expMsg);
`ifdef RECEIVE_ERROR_EN
        chk("error", bus.error, expErr);
`endif
        chk("mem_chan", mem[ch], expMem0);
        chk("mem_msg", mem[msgAddr], w1);
        chk("write_count", writeCount - wc0, expWrite ? 1 : 0);
        bus.start = 1'b0;
        if (chainPoke) begin
            pokeEn = 1'b1; pokeAddr = pa; pokeData = pd;
        end
        @(negedge clk); // T+4
        chk("busy_t4", bus.busy, 0);
        chk("finished_t4", bus.finished, 0);
        if (!chainPoke) chk("hold_results", bus.shouldScheduleSender, expSched);
    endtask

    initial begin
        int wc;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.channel = '0;
        bus.rxPid = '0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_finished", bus.finished, 0);
        chk("rst_rw", bus.readWriteMode, `RAM_READ);
        chk("rst_sched", bus.shouldScheduleSender, 0);
        chk("rst_desched", bus.shouldDescheduleReceiver, 0);
        chk("rst_valid", bus.messageValid, 0);
        chk("rst_txpid", bus.scheduleTxPid, 0);
        chk("rst_msg", bus.receivedMessage, 0);
`ifdef RECEIVE_ERROR_EN
        chk("rst_error", bus.error, 0);
`endif
        @(negedge clk);
        for (int i = 0; i < MEMWORDS; i++) poke(AB'(i), DB'($urandom));
        reset = 1'b0;
        @(negedge clk);

        // Empty channel parks the receiver
        poke(AB'('h10), '0);
        poke(AB'('h11), DB'('h1234));
        runOp(AB'('h10), AB'(3), 1'b0, 1'b0, '0, '0);

        // Waiting sender hands over its message
        poke(AB'('h10), DB'(5));
        poke(AB'('h11), DB'('hBEEF));
        runOp(AB'('h10), AB'(3), 1'b0, 1'b0, '0, '0);

        // Back-to-back: second start at T+4 sees sender 7
        poke(AB'('h10), '0);
        runOp(AB'('h10), AB'(3), 1'b0, 1'b1, AB'('h10), DB'(7));
        runOp(AB'('h10), AB'(3), 1'b0, 1'b0, '0, '0);
        chk("b2b_txpid", bus.scheduleTxPid, 7);

        // Reset during READ_PID abandons the operation
        poke(AB'('h10), '0);
        wc = writeCount;
        bus.start = 1'b1; bus.channel = AB'('h10); bus.rxPid = AB'(3);
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rw", bus.readWriteMode, `RAM_READ);
        chk("midrst_desched", bus.shouldDescheduleReceiver, 0);
        chk("midrst_sched", bus.shouldScheduleSender, 0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_writes", writeCount - wc, 0);
        chk("midrst_mem", mem[AB'('h10)], 0);
        chk("midrst_finished", bus.finished, 0);
        reset = 1'b0;
        @(negedge clk);
        runOp(AB'('h10), AB'(3), 1'b0, 1'b0, '0, '0);

        // Top-of-space channel wraps the message read; start held while busy is ignored
        poke('1, DB'(2));
        poke('0, DB'('h42));
        runOp('1, AB'(3), 1'b1, 1'b0, '0, '0);
        chk("wrap_msg", bus.receivedMessage, 'h42);
        wc = writeCount;
        @(negedge clk);
        chk("ignored_busy", bus.busy, 0);
        chk("ignored_writes", writeCount - wc, 0);

        // Receiver already waiting on the channel
        poke(AB'('h10), DB'(3));
        poke(AB'('h11), DB'('h5555));
        runOp(AB'('h10), AB'(3), 1'b0, 1'b0, '0, '0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [AB-1:0] ch, rx, pid;
            logic [DB-1:0] w;
            int kind;
            ch = AB'($urandom_range(0, MEMWORDS - 1));
            rx = AB'($urandom_range(1, MEMWORDS - 1));
            kind = $urandom_range(0, 3);
            pid = (kind == 0) ? '0 : (kind == 1) ? rx : AB'($urandom);
            w = DB'($urandom);
            w[AB-1:0] = pid;
            poke(ch, w);
            poke(ch + AB'(1), DB'($urandom));
            runOp(ch, rx, n[0], 1'b0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
